// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring sequence checker: FSM states and
// width-generic one-hot rotations.
package ring_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_ERROR
    } ring_state_t;

    localparam int RING_NBITS    = 4;
    localparam int RING_MAX_BITS = 32;

    typedef logic [RING_MAX_BITS-1:0] ring_vec_t;

    // Rotations act on the low n bits of p; callers zero-extend the ring
    // pattern into ring_vec_t and slice the result back down.
    function automatic ring_vec_t rotl1(input ring_vec_t p, input int unsigned n);
        ring_vec_t mask;
        mask = (ring_vec_t'(1) << n) - ring_vec_t'(1);
        return ((p << 1) | (p >> (n - 1))) & mask;
    endfunction

    function automatic ring_vec_t rotr1(input ring_vec_t p, input int unsigned n);
        ring_vec_t mask;
        mask = (ring_vec_t'(1) << n) - ring_vec_t'(1);
        return ((p >> 1) | ((p & ring_vec_t'(1)) << (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Classifies a ring pattern (zero / one-hot) and returns the index of its
// lowest set bit.
module onehot_encoder #(
    parameter int NBITS_RING = 4,
    parameter int NBITS_IDX  = $clog2(NBITS_RING)
) (
    input  logic [NBITS_RING-1:0] ring,
    output logic [NBITS_IDX-1:0]  idx,
    output logic                  is_zero,
    output logic                  is_onehot
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        idx = '0;
        for (int i = NBITS_RING - 1; i >= 0; i--) begin
            if (ring[i]) idx = NBITS_IDX'(i);
        end
    end

    assign is_zero   = (ring == '0);
    assign is_onehot = !is_zero && ((ring & (ring - NBITS_RING'(1))) == '0);

endmodule

// File: rtl/ring_sequence_checker.sv
// Checks a sampled one-hot ring counter against its legal rotation sequence,
// recovering position, direction and laps and counting illegal events.
module ring_sequence_checker
    import ring_pkg::*;
#(
    parameter int NBITS_RING = RING_NBITS,
    parameter int NBITS_IDX  = $clog2(NBITS_RING),
    parameter int NBITS_LAP  = 4,
    parameter int NBITS_ERR  = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic                  clr,
    input  logic [NBITS_RING-1:0] ring_in,
    output logic [NBITS_IDX-1:0]  idx,
    output logic                  idx_valid,
    output logic                  dir,
    output logic                  dir_known,
    output logic                  step,
    output logic [NBITS_LAP-1:0]  lap_count,
    output logic                  err_sticky,
    output logic [NBITS_ERR-1:0]  err_count
);

    ring_state_t           state_q, state_d;
    logic [NBITS_RING-1:0] prev_q, prev_d;
    logic [NBITS_IDX-1:0]  idx_q, idx_d;
    logic                  idx_valid_q, idx_valid_d;
    logic                  dir_q, dir_d;
    logic                  dir_known_q, dir_known_d;
    logic                  step_q, step_d;
    logic [NBITS_LAP-1:0]  lap_q, lap_d;
    logic                  sticky_q, sticky_d;
    logic [NBITS_ERR-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_event;

    logic [NBITS_IDX-1:0]  in_idx;
    logic                  in_zero, in_onehot;
    ring_vec_t             fwd_ext, rev_ext;
    logic [NBITS_RING-1:0] fwd_pat, rev_pat;

    onehot_encoder #(
        .NBITS_RING(NBITS_RING),
        .NBITS_IDX (NBITS_IDX)
    ) u_enc (
        .ring     (ring_in),
        .idx      (in_idx),
        .is_zero  (in_zero),
        .is_onehot(in_onehot)
    );

    assign fwd_ext = rotl1(ring_vec_t'(prev_q), NBITS_RING);
    assign rev_ext = rotr1(ring_vec_t'(prev_q), NBITS_RING);
    assign fwd_pat = fwd_ext[NBITS_RING-1:0];
    assign rev_pat = rev_ext[NBITS_RING-1:0];

    // NOTE: every next-state variable gets a default first so no path through
    // this block leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        idx_d       = idx_q;
        dir_d       = dir_q;
        dir_known_d = dir_known_q;
        step_d      = 1'b0;
        lap_d       = lap_q;
        sticky_d    = sticky_q;
        err_cnt_d   = err_cnt_q;
        err_event   = 1'b0;

        if (sample_en) begin
            case (state_q)
                S_TRACK: begin
                    if (ring_in == prev_q) begin
                        state_d = S_TRACK;
                    end else if (in_zero) begin
                        state_d = S_IDLE;
                    end else if (ring_in == fwd_pat && (!dir_known_q || !dir_q)) begin
                        // With two bits fwd == rev, so this branch claims it as forward.
                        step_d      = 1'b1;
                        dir_d       = 1'b0;
                        dir_known_d = 1'b1;
                        prev_d      = ring_in;
                        idx_d       = in_idx;
                        if (prev_q[NBITS_RING-1]) lap_d = lap_q + NBITS_LAP'(1);
                    end else if (ring_in == rev_pat && (!dir_known_q || dir_q)) begin
                        step_d      = 1'b1;
                        dir_d       = 1'b1;
                        dir_known_d = 1'b1;
                        prev_d      = ring_in;
                        idx_d       = in_idx;
                        if (prev_q[0]) lap_d = lap_q + NBITS_LAP'(1);
                    end else begin
                        state_d   = S_ERROR;
                        err_event = 1'b1;
                    end
                end
                default: begin
                    // S_IDLE and S_ERROR react identically to every input class.
                    if (in_zero) begin
                        state_d = S_IDLE;
                    end else if (in_onehot) begin
                        state_d     = S_TRACK;
                        prev_d      = ring_in;
                        idx_d       = in_idx;
                        dir_known_d = 1'b0;
                    end else begin
                        state_d   = S_ERROR;
                        err_event = 1'b1;
                    end
                end
            endcase
        end

        if (err_event) begin
            sticky_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + NBITS_ERR'(1);
        end

        if (clr) begin
            lap_d     = '0;
            err_cnt_d = '0;
            sticky_d  = 1'b0;
        end

        idx_valid_d = (state_d == S_TRACK);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            dir_known_q <= 1'b0;
            step_q      <= 1'b0;
            lap_q       <= '0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            dir_q       <= dir_d;
            dir_known_q <= dir_known_d;
            step_q      <= step_d;
            lap_q       <= lap_d;
            sticky_q    <= sticky_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign dir        = dir_q;
    assign dir_known  = dir_known_q;
    assign step       = step_q;
    assign lap_count  = lap_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Scoreboard bench for ring_sequence_checker: a position-based reference model
// predicts each edge's outputs and a monitor compares them one cycle later.
module tb_ring_sequence_checker;

    localparam int N = 4;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] ring_in = '0;
    logic [1:0] idx;
    logic       idx_valid, dir, dir_known, step, err_sticky;
    logic [3:0] lap_count, err_count;

    ring_sequence_checker dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .sample_en (sample_en),
        .clr       (clr),
        .ring_in   (ring_in),
        .idx       (idx),
        .idx_valid (idx_valid),
        .dir       (dir),
        .dir_known (dir_known),
        .step      (step),
        .lap_count (lap_count),
        .err_sticky(err_sticky),
        .err_count (err_count)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        int idx;
        int idx_valid;
        int dir;
        int dir_known;
        int step;
        int lap;
        int sticky;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: tracking flag plus integer position of the set bit.
    bit m_track, m_dir, m_dk, m_step, m_sticky;
    int m_pos, m_lap, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_track = 0; m_pos = 0; m_dir = 0; m_dk = 0; m_step = 0;
        m_lap = 0; m_sticky = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(bit en, bit c, logic [3:0] r);
        int ones = $countones(r);
        int np = 0;
        bit err = 0;
        m_step = 0;
        if (en) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) np = i;
            if (!m_track) begin
                if (ones == 1) begin m_track = 1; m_pos = np; m_dk = 0; end
                else if (ones > 1) err = 1;
            end else if (ones == 0) begin
                m_track = 0;
            end else if (ones > 1) begin
                err = 1; m_track = 0;
            end else if (np == m_pos) begin
                m_step = 0;
            end else if (np == (m_pos + 1) % N && (!m_dk || !m_dir)) begin
                m_step = 1;
                if (m_pos == N - 1) m_lap = (m_lap + 1) % 16;
                m_dir = 0; m_dk = 1; m_pos = np;
            end else if (np == (m_pos + N - 1) % N && (!m_dk || m_dir)) begin
                m_step = 1;
                if (m_pos == 0) m_lap = (m_lap + 1) % 16;
                m_dir = 1; m_dk = 1; m_pos = np;
            end else begin
                err = 1; m_track = 0;
            end
        end
        if (err) begin
            m_sticky = 1;
            if (m_cnt < 15) m_cnt++;
        end
        if (c) begin
            m_lap = 0; m_cnt = 0; m_sticky = 0;
        end
    endfunction

    task automatic drive(input bit rst, input bit en, input bit c, input logic [3:0] r);
        exp_t e;
        @(negedge clk_2);
        reset = rst; sample_en = en; clr = c; ring_in = r;
        if (rst) model_reset();
        else model_step(en, c, r);
        e.idx = m_pos; e.idx_valid = m_track; e.dir = m_dir; e.dir_known = m_dk;
        e.step = m_step; e.lap = m_lap; e.sticky = m_sticky; e.cnt = m_cnt;
        @(posedge clk_2);
        #1;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs settle after each edge, so compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_2);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("idx",        32'(idx),        e.idx);
                check("idx_valid",  32'(idx_valid),  e.idx_valid);
                check("dir",        32'(dir),        e.dir);
                check("dir_known",  32'(dir_known),  e.dir_known);
                check("step",       32'(step),       e.step);
                check("lap_count",  32'(lap_count),  e.lap);
                check("err_sticky", 32'(err_sticky), e.sticky);
                check("err_count",  32'(err_count),  e.cnt);
            end
        end
    end

    initial begin
        logic [3:0] ill [11];
        logic [3:0] cur, r;
        bit         pref_rev;
        int         sel;
        ill = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
        pref_rev = 0;

        drive(1, 0, 0, 4'h0);
        drive(1, 1, 0, 4'h5);

        // Forward lap, then a reverse run after the generator restarts.
        foreach (ill[i]) if (i < 1) drive(0, 1, 0, 4'h0);
        drive(0, 1, 0, 4'h1); drive(0, 1, 0, 4'h2); drive(0, 1, 0, 4'h4);
        drive(0, 1, 0, 4'h8); drive(0, 1, 0, 4'h1);
        drive(0, 1, 0, 4'h0);
        drive(0, 1, 0, 4'h8); drive(0, 1, 0, 4'h4); drive(0, 1, 0, 4'h2);
        drive(0, 1, 0, 4'h1); drive(0, 1, 0, 4'h8); drive(0, 1, 0, 4'h4);

        // Skip error, resync, then reversal error and illegal saturation.
        drive(0, 1, 0, 4'h1); drive(0, 1, 0, 4'h1);
        drive(0, 1, 0, 4'h2); drive(0, 1, 0, 4'h1);
        repeat (3) drive(0, 1, 0, 4'h6);
        repeat (16) drive(0, 1, 0, 4'h6);

        // Freeze while garbage toggles, then a zero returns to idle.
        drive(0, 1, 0, 4'h1); drive(0, 1, 0, 4'h2); drive(0, 1, 0, 4'h4);
        repeat (5) drive(0, 0, 0, 4'($urandom));
        drive(0, 1, 0, 4'h0);

        // clr on an illegal sample, then a reset that overrides everything.
        drive(0, 1, 0, 4'h8); drive(0, 1, 0, 4'h1);
        drive(0, 1, 1, 4'h3);
        drive(0, 1, 0, 4'h2); drive(0, 1, 0, 4'h4);
        drive(1, 1, 1, 4'h8);
        drive(0, 1, 0, 4'h8);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) pref_rev = !pref_rev;
            cur = m_track ? 4'(1 << m_pos) : 4'(1 << $urandom_range(0, 3));
            sel = $urandom_range(0, 99);
            if (sel < 50)      r = pref_rev ? {cur[0], cur[3:1]} : {cur[2:0], cur[3]};
            else if (sel < 56) r = pref_rev ? {cur[2:0], cur[3]} : {cur[0], cur[3:1]};
            else if (sel < 68) r = cur;
            else if (sel < 75) r = 4'h0;
            else if (sel < 85) r = ill[$urandom_range(0, 10)];
            else               r = 4'($urandom);
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 49) == 0, r);
        end

        drive(0, 0, 0, 4'h0);
        repeat (3) @(posedge clk_2);
        #1;
        check("queue_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
